// File: rtl/fir_requant.sv
// Requantizes signed FIR accumulator samples (round, shift, saturate) behind a
// 2-entry skid buffer, with per-frame last marking and a saturation counter.
module fir_requant #(
    parameter int unsigned DATA_IN   = 32,
    parameter int unsigned DATA_OUT  = 16,
    parameter int unsigned SHIFT     = 7,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic                axi_clk,
    input  logic                axi_reset_n,
    input  logic                s_axis_valid,
    input  logic [DATA_IN-1:0]  s_axis_data,
    output logic                s_axis_ready,
    output logic                m_axis_valid,
    output logic [DATA_OUT-1:0] m_axis_data,
    output logic                m_axis_last,
    input  logic                m_axis_ready,
    input  logic                sat_clr,
    output logic [15:0]         sat_count
);

    localparam int unsigned WI = DATA_IN + 1;

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    localparam logic signed [WI-1:0] RndV =
        (SHIFT == 0) ? '0 : (WI'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam logic signed [WI-1:0] MaxV =
        {{(WI - DATA_OUT + 1){1'b0}}, {(DATA_OUT - 1){1'b1}}};
    localparam logic signed [WI-1:0] MinV =
        {{(WI - DATA_OUT + 1){1'b1}}, {(DATA_OUT - 1){1'b0}}};
    localparam logic [15:0] LastCnt = 16'(FRAME_LEN - 1);

    logic [1:0]          state_q, state_d;
    logic [DATA_OUT-1:0] out_data_q, out_data_d;
    logic [DATA_OUT-1:0] skid_data_q, skid_data_d;
    logic                ready_q, ready_d;
    logic [15:0]         beat_cnt_q, beat_cnt_d;
    logic [15:0]         sat_cnt_q, sat_cnt_d;

    logic signed [WI-1:0] x_ext, sum, r;
    logic [DATA_OUT-1:0]  q_data;
    logic                 q_sat;
    logic                 accept, out_fire;

    // One extra bit of headroom so the rounding add can never wrap.
    always_comb begin
        x_ext = {s_axis_data[DATA_IN-1], s_axis_data};
        sum   = x_ext + RndV;
        r     = sum >>> SHIFT;
        q_sat = 1'b0;
        if (r > MaxV) begin
            q_data = MaxV[DATA_OUT-1:0];
            q_sat  = 1'b1;
        end else if (r < MinV) begin
            q_data = MinV[DATA_OUT-1:0];
            q_sat  = 1'b1;
        end else begin
            q_data = r[DATA_OUT-1:0];
        end
    end

    assign accept   = s_axis_valid & ready_q;
    assign out_fire = (state_q != StEmpty) & m_axis_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d    = StOne;
                    out_data_d = q_data;
                end
            end
            StOne: begin
                if (accept && !out_fire) begin
                    state_d     = StFull;
                    skid_data_d = q_data;
                end else if (!accept && out_fire) begin
                    state_d = StEmpty;
                end else if (accept && out_fire) begin
                    out_data_d = q_data;
                end
            end
            StFull: begin
                if (out_fire) begin
                    state_d    = StOne;
                    out_data_d = skid_data_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        ready_d = (state_d != StFull);
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_fire) begin
            beat_cnt_d = (beat_cnt_q == LastCnt) ? 16'd0 : beat_cnt_q + 16'd1;
        end
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = 16'd0;
        end else if (accept && q_sat && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= StEmpty;
            out_data_q  <= '0;
            skid_data_q <= '0;
            ready_q     <= 1'b0;
            beat_cnt_q  <= 16'd0;
            sat_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            ready_q     <= ready_d;
            beat_cnt_q  <= beat_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign s_axis_ready = ready_q;
    assign m_axis_valid = (state_q != StEmpty);
    assign m_axis_data  = out_data_q;
    assign m_axis_last  = m_axis_valid && (beat_cnt_q == LastCnt);
    assign sat_count    = sat_cnt_q;

endmodule

// File: tb/tb_fir_requant.sv
// Directed-vector bench for fir_requant: rounding, saturation, backpressure,
// framing and mid-stream reset.
module tb_fir_requant;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        s_axis_valid;
    logic [31:0] s_axis_data;
    logic        s_axis_ready;
    logic        m_axis_valid;
    logic [15:0] m_axis_data;
    logic        m_axis_last;
    logic        m_axis_ready;
    logic        sat_clr;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    fir_requant #(
        .DATA_IN  (32),
        .DATA_OUT (16),
        .SHIFT    (7),
        .FRAME_LEN(4)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .s_axis_valid(s_axis_valid),
        .s_axis_data (s_axis_data),
        .s_axis_ready(s_axis_ready),
        .m_axis_valid(m_axis_valid),
        .m_axis_data (m_axis_data),
        .m_axis_last (m_axis_last),
        .m_axis_ready(m_axis_ready),
        .sat_clr     (sat_clr),
        .sat_count   (sat_count)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        s_axis_valid = 1'b0;
        sat_clr      = 1'b0;
        axi_reset_n  = 1'b0;
        step();
        step();
        axi_reset_n = 1'b1;
        step();
        check("ready_after_reset", {31'b0, s_axis_ready}, 32'd1);
    endtask

    // Drive one beat and check it one cycle later with m_axis_ready held high.
    task automatic send(input string tag, input logic [31:0] x, input logic [15:0] exp);
        s_axis_valid = 1'b1;
        s_axis_data  = x;
        step();
        check({tag, "_valid"}, {31'b0, m_axis_valid}, 32'd1);
        check({tag, "_data"}, {16'b0, m_axis_data}, {16'b0, exp});
    endtask

    initial begin
        axi_reset_n  = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        m_axis_ready = 1'b1;
        sat_clr      = 1'b0;

        // Reset state
        step();
        check("rst_ready", {31'b0, s_axis_ready}, 32'd0);
        check("rst_valid", {31'b0, m_axis_valid}, 32'd0);
        check("rst_data", {16'b0, m_axis_data}, 32'd0);
        check("rst_last", {31'b0, m_axis_last}, 32'd0);
        check("rst_sat", {16'b0, sat_count}, 32'd0);
        step();
        axi_reset_n = 1'b1;
        #1;
        check("ready_before_edge", {31'b0, s_axis_ready}, 32'd0);
        step();
        check("ready_first_edge", {31'b0, s_axis_ready}, 32'd1);

        // Rounding
        send("rnd_1280", 32'd1280, 16'd10);
        send("rnd_64", 32'd64, 16'd1);
        send("rnd_63", 32'd63, 16'd0);
        send("rnd_m64", -32'sd64, 16'd0);
        send("rnd_m65", -32'sd65, 16'hFFFF);
        s_axis_valid = 1'b0;
        step();
        check("rnd_drain", {31'b0, m_axis_valid}, 32'd0);

        // Saturation and sat_count
        do_reset();
        send("sat_pos", 32'h7FFF_FFFF, 16'h7FFF);
        send("sat_neg", 32'h8000_0000, 16'h8000);
        check("sat_cnt2", {16'b0, sat_count}, 32'd2);
        sat_clr = 1'b1;
        send("sat_clr_beat", 32'h7FFF_FFFF, 16'h7FFF);
        check("sat_clr_wins", {16'b0, sat_count}, 32'd0);
        sat_clr      = 1'b0;
        s_axis_valid = 1'b0;
        step();
        check("sat_cnt_hold0", {16'b0, sat_count}, 32'd0);
        send("sat_again", 32'h8000_0000, 16'h8000);
        check("sat_cnt1", {16'b0, sat_count}, 32'd1);
        s_axis_valid = 1'b0;
        step();

        // Backpressure
        do_reset();
        m_axis_ready = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = 32'd128;
        step();
        check("bp_one_data", {16'b0, m_axis_data}, 32'd1);
        check("bp_one_ready", {31'b0, s_axis_ready}, 32'd1);
        s_axis_data = 32'd256;
        step();
        check("bp_full_data", {16'b0, m_axis_data}, 32'd1);
        check("bp_full_ready", {31'b0, s_axis_ready}, 32'd0);
        s_axis_data = 32'd384;
        step();
        check("bp_stall_data", {16'b0, m_axis_data}, 32'd1);
        check("bp_stall_ready", {31'b0, s_axis_ready}, 32'd0);
        m_axis_ready = 1'b1;
        step();
        check("bp_out2", {16'b0, m_axis_data}, 32'd2);
        check("bp_ready_back", {31'b0, s_axis_ready}, 32'd1);
        step();
        check("bp_out3", {16'b0, m_axis_data}, 32'd3);
        s_axis_data = 32'd512;
        step();
        check("bp_out4", {16'b0, m_axis_data}, 32'd4);
        s_axis_valid = 1'b0;
        step();
        check("bp_drain", {31'b0, m_axis_valid}, 32'd0);

        // Framing with a stall on the last beat of the first frame
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            send("frm", 32'(k * 128), 16'(k));
            check("frm_last", {31'b0, m_axis_last}, ((k == 4) || (k == 8)) ? 32'd1 : 32'd0);
            if (k == 4) begin
                s_axis_valid = 1'b0;
                m_axis_ready = 1'b0;
                step();
                step();
                check("frm_stall_data", {16'b0, m_axis_data}, 32'd4);
                check("frm_stall_last", {31'b0, m_axis_last}, 32'd1);
                m_axis_ready = 1'b1;
            end
        end
        s_axis_valid = 1'b0;
        step();

        // Reset while FULL
        do_reset();
        m_axis_ready = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = 32'd1280;
        step();
        s_axis_data = 32'd2560;
        step();
        check("mid_full_ready", {31'b0, s_axis_ready}, 32'd0);
        #1;
        axi_reset_n = 1'b0;
        #1;
        check("mid_valid", {31'b0, m_axis_valid}, 32'd0);
        check("mid_data", {16'b0, m_axis_data}, 32'd0);
        check("mid_ready", {31'b0, s_axis_ready}, 32'd0);
        check("mid_last", {31'b0, m_axis_last}, 32'd0);
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        step();
        axi_reset_n = 1'b1;
        step();
        check("mid_ready_back", {31'b0, s_axis_ready}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            send("mid_beat", 32'(k * 128), 16'(k));
            check("mid_beat_last", {31'b0, m_axis_last}, (k == 4) ? 32'd1 : 32'd0);
        end
        s_axis_valid = 1'b0;
        step();
        check("mid_drain", {31'b0, m_axis_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_requant.md
FIR_REQUANT -- requirements
Module: fir_requant

Interface
REQ-001 SHALL have parameter DATA_IN, default 32, width of the incoming signed FIR accumulator sample.
REQ-002 SHALL have parameter DATA_OUT, default 16, width of the outgoing signed sample.
REQ-003 SHALL have parameter SHIFT, default 7, arithmetic right-shift applied before saturation; legal range 0..DATA_IN-1.
REQ-004 SHALL have parameter FRAME_LEN, default 256, output beats per frame; legal range 2..65536.
REQ-005 SHALL have port axi_clk, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL have port axi_reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port s_axis_valid, input, 1, upstream sample valid.
REQ-008 SHALL have port s_axis_data, input, DATA_IN, signed upstream sample.
REQ-009 SHALL have port s_axis_ready, output, 1, registered ready to upstream.
REQ-010 SHALL have port m_axis_valid, output, 1, downstream sample valid.
REQ-011 SHALL have port m_axis_data, output, DATA_OUT, signed requantized sample.
REQ-012 SHALL have port m_axis_last, output, 1, marks the final beat of each frame.
REQ-013 SHALL have port m_axis_ready, input, 1, downstream ready.
REQ-014 SHALL have port sat_clr, input, 1, synchronous clear of sat_count.
REQ-015 SHALL have port sat_count, output, 16, count of accepted beats that saturated.

Function
REQ-016 Input handshake: a beat SHALL be accepted on a rising edge where s_axis_valid and s_axis_ready are both 1; output handshake likewise with m_axis_valid and m_axis_ready.
REQ-017 Arithmetic: the block SHALL compute r = (x + 2^(SHIFT-1)) >>> SHIFT with at least DATA_IN+1 bits internally, so no intermediate wraps; for SHIFT=0, r = x.
REQ-018 Saturation: r > 2^(DATA_OUT-1)-1 SHALL give 2^(DATA_OUT-1)-1; r < -2^(DATA_OUT-1) SHALL give -2^(DATA_OUT-1); the beat SHALL be flagged saturated.
REQ-019 Buffering: a 2-entry skid buffer SHALL hold the data: an output register plus a skid register, each with valid.
REQ-020 State machine: EMPTY (no entry valid), ONE (output reg valid), FULL (both valid).
REQ-021 EMPTY transitions: accept -> ONE.
REQ-022 ONE transitions: accept with no output handshake -> FULL; output handshake with no accept -> EMPTY; accept and output handshake together -> ONE, with the new beat in the output reg.
REQ-023 FULL transitions: output handshake -> ONE, with the skid entry moved to the output reg; no accept is possible in FULL.
REQ-024 Ready: s_axis_ready SHALL be 1 exactly when the next state is not FULL, so throughput is 1 beat/cycle when m_axis_ready=1.
REQ-025 Latency: a beat accepted at edge N SHALL appear on m_axis_data/m_axis_valid after edge N when the buffer was EMPTY.
REQ-026 Ordering: beats SHALL leave in acceptance order with no loss or duplication.
REQ-027 Stall stability: while m_axis_valid=1 and m_axis_ready=0, m_axis_data and m_axis_last SHALL hold stable.
REQ-028 Frame counter: a 16-bit beat counter SHALL increment on each output handshake and wrap from FRAME_LEN-1 to 0.
REQ-029 Last flag: m_axis_last SHALL be 1 when m_axis_valid=1 and the counter = FRAME_LEN-1, and 0 otherwise.
REQ-030 sat_count SHALL increment on each accepted saturated beat and stick at 0xFFFF.
REQ-031 sat_clr=1 SHALL set sat_count to 0 on the next edge; a simultaneous increment SHALL be discarded (clear wins).

Reset
REQ-032 While axi_reset_n=0, the block SHALL hold: s_axis_ready=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, sat_count=0, beat counter=0, state=EMPTY.
REQ-033 s_axis_ready SHALL rise on the first clock edge after reset deassertion.
REQ-034 Reset asserted mid-operation SHALL discard all buffered beats immediately, without waiting for a clock edge.

Verification
REQ-035 Rounding (SHIFT=7, m_axis_ready=1): input 1280 -> 10; 64 -> 1; 63 -> 0; -64 -> 0; -65 -> -1; each appears 1 cycle after acceptance.
REQ-036 Saturation: input 0x7FFFFFFF -> 32767; input 0x80000000 -> -32768; sat_count reads 2; then sat_clr pulse with a saturated beat in the same cycle -> sat_count reads 0.
REQ-037 Backpressure: stream 1,2,3,4 (x128), with m_axis_ready=0 for 3 cycles -> 1 and 2 buffered, s_axis_ready drops, then output 1,2,3,4 in order with data stable during the stall.
REQ-038 Framing: FRAME_LEN=4, 10 beats -> m_axis_last=1 on beats 4 and 8 only; the counter is unaffected by stalls.
REQ-039 Reset mid-stream: assert axi_reset_n=0 while FULL -> outputs zero immediately; after release, the first new beat appears with counter restarted (last on beat FRAME_LEN).
